rst_clk_seq: RTL and testbench

- Parametrised clock-enable and reset sequencer for board-level and simulation tops.
- Takes the single fabric clock and an external active-low reset button, stretches and synchronises the reset, then releases NUM_DOM reset domains in a fixed order.
- Generates a per-domain divided clock-enable, plus a single-step debug mode for stepping the CPU and peripherals.
- All downstream logic runs on clk, gated by clk_en; no derived clocks are produced.

---
 rtl/rst_clk_seq.sv | 192 +++++++++++++++++++
 tb/tb_rst_clk_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/rst_clk_seq.sv
// Reset stretcher / domain release sequencer with per-domain divided clock-enables
// and a single-step debug mode. Everything runs on clk; no derived clocks.
module rst_clk_seq #(
  parameter int NUM_DOM = 4,
  parameter int DIV_W   = 8,
  parameter int STRETCH = 16,
  parameter int GAP     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ext_rstn,
  input  logic [NUM_DOM*DIV_W-1:0] div_ratio,
  input  logic                     step_mode,
  input  logic                     step,
  output logic [NUM_DOM-1:0]       dom_rst,
  output logic [NUM_DOM-1:0]       clk_en,
  output logic                     ready
);

  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_STRETCH = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_RUN     = 2'd3;

  localparam int SC_W  = $clog2(STRETCH + 1);
  localparam int GC_W  = $clog2(GAP + 1);
  localparam int IDX_W = $clog2(NUM_DOM + 1);

  // The HOLD edge that first sees sync_n high already counts as one stretch cycle.
  localparam logic [SC_W-1:0]  ST_LAST  = SC_W'((STRETCH >= 2) ? STRETCH - 2 : 0);
  localparam logic [GC_W-1:0]  GAP_LAST = GC_W'(GAP - 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_DOM);
  localparam bit               ST_ONE   = (STRETCH == 1);

  logic             sync_1;
  logic             sync_n;
  logic [1:0]       state;
  logic [SC_W-1:0]  st_cnt;
  logic [GC_W-1:0]  gap_cnt;
  logic [IDX_W-1:0] idx;
  logic             step_q;
  logic             step_mode_q;
  logic             run_phase;
  logic             step_edge;

  // Two-flop synchroniser for the external reset button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_n <= 1'b0;
    end else begin
      sync_1 <= ext_rstn;
      sync_n <= sync_1;
    end
  end

  // Registered copies used for step edge detection and step-mode exit detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q      <= 1'b0;
      step_mode_q <= 1'b0;
    end else begin
      step_q      <= step;
      step_mode_q <= step_mode;
    end
  end

  assign run_phase = (state == S_RELEASE) || (state == S_RUN);
  assign step_edge = step & ~step_q & run_phase;

  // Sequencer: stretch, then release domains 0..NUM_DOM-1 GAP cycles apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_HOLD;
      st_cnt  <= '0;
      gap_cnt <= '0;
      idx     <= '0;
      dom_rst <= '1;
      ready   <= 1'b0;
    end else if (!sync_n) begin
      state   <= S_HOLD;
      st_cnt  <= '0;
      gap_cnt <= '0;
      idx     <= '0;
      dom_rst <= '1;
      ready   <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          st_cnt <= '0;
          if (ST_ONE) begin
            state      <= S_RELEASE;
            dom_rst[0] <= 1'b0;
            idx        <= IDX_W'(1);
            gap_cnt    <= '0;
          end else begin
            state <= S_STRETCH;
          end
        end
        S_STRETCH: begin
          if (st_cnt == ST_LAST) begin
            state      <= S_RELEASE;
            dom_rst[0] <= 1'b0;
            idx        <= IDX_W'(1);
            gap_cnt    <= '0;
          end else begin
            st_cnt <= st_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            if (idx == IDX_END) begin
              state <= S_RUN;
              ready <= 1'b1;
            end else begin
              for (int k = 0; k < NUM_DOM; k++) begin
                if (idx == IDX_W'(k)) begin
                  dom_rst[k] <= 1'b0;
                end
              end
              idx <= idx + 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_RUN: begin
          state <= S_RUN;
        end
        default: begin
          state   <= S_HOLD;
          dom_rst <= '1;
          ready   <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_dom
    logic [DIV_W-1:0] ratio_in;
    logic [DIV_W-1:0] r;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;
    logic             wrap;
    logic             en;

    assign ratio_in = div_ratio[gi*DIV_W +: DIV_W];

    // Ratios 0 and 1 both mean "enable every cycle".
    always_comb begin
      last = '0;
      if (r < DIV_W'(2)) begin
        last = '0;
      end else begin
        last = r - DIV_W'(1);
      end
    end

    assign wrap = (cnt >= last);

    // Divider: ratio is only re-latched at a period wrap, so mid-period writes never shorten a period.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r   <= '0;
        cnt <= '0;
        en  <= 1'b0;
      end else if (dom_rst[gi] || !sync_n) begin
        r   <= ratio_in;
        cnt <= '0;
        en  <= 1'b0;
      end else if (step_mode) begin
        en <= step_edge;
      end else if (step_mode_q) begin
        r   <= ratio_in;
        cnt <= '0;
        en  <= 1'b0;
      end else begin
        en <= wrap;
        if (wrap) begin
          cnt <= '0;
          r   <= ratio_in;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign clk_en[gi] = en;
  end

endmodule

// File: tb/tb_rst_clk_seq.sv
// Directed bench for rst_clk_seq: power-up sequence, dividers, ratio change,
// single-step, reset glitches in RUN and STRETCH, and asynchronous reset.
module tb_rst_clk_seq;

  logic        clk;
  logic        rst;
  logic        ext_rstn;
  logic [31:0] div_ratio;
  logic        step_mode;
  logic        step;
  logic [3:0]  dom_rst;
  logic [3:0]  clk_en;
  logic        ready;

  int checks;
  int errors;
  int edge_n;

  rst_clk_seq #(
    .NUM_DOM(4),
    .DIV_W  (8),
    .STRETCH(16),
    .GAP    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ext_rstn (ext_rstn),
    .div_ratio(div_ratio),
    .step_mode(step_mode),
    .step     (step),
    .dom_rst  (dom_rst),
    .clk_en   (clk_en),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge %0d got %h exp %h", tag, edge_n, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  // Expected {ready, dom_rst, clk_en} for a sequence whose sync_n first goes high after edge b,
  // with dom0 ratio 3 (or the 3->5 change written after edge 25 when chg is set), dom1 ratio 4,
  // dom2 ratio 0 and dom3 ratio 1.
  function automatic logic [8:0] exp_seq(input int e, input int b, input bit chg);
    logic [3:0] dr;
    logic [3:0] en;
    logic       rdy;
    for (int k = 0; k < 4; k++) dr[k] = (e < b + 16 + 4 * k);
    rdy = (e >= b + 32);
    if (chg) en[0] = (e == 21) || (e == 24) || (e == 27) || (e >= 32 && (e - 32) % 5 == 0);
    else     en[0] = (e >= b + 19) && ((e - b - 19) % 3 == 0);
    en[1] = (e >= b + 24) && ((e - b - 24) % 4 == 0);
    en[2] = (e >= b + 25);
    en[3] = (e >= b + 29);
    return {rdy, dr, en};
  endfunction

  initial begin
    logic [8:0] exp_v;
    checks    = 0;
    errors    = 0;
    edge_n    = 0;
    rst       = 1'b1;
    ext_rstn  = 1'b1;
    div_ratio = {8'd1, 8'd0, 8'd4, 8'd3};
    step_mode = 1'b0;
    step      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_hold", {23'd0, ready, dom_rst, clk_en}, {23'd0, 1'b0, 4'hF, 4'h0});
    rst    = 1'b0;
    edge_n = 0;

    // Power-up sequence, dividers, and dom0 ratio change 3->5 mid-period.
    for (int e = 1; e <= 43; e++) begin
      adv();
      check_val("powerup", {23'd0, ready, dom_rst, clk_en}, {23'd0, exp_seq(e, 2, 1'b1)});
      if (e == 25) div_ratio[7:0] = 8'd5;
      if (e == 43) step_mode = 1'b1;
    end

    // Single-step: three step presses, each held two cycles.
    for (int e = 44; e <= 60; e++) begin
      adv();
      exp_v = {1'b1, 4'h0, ((e == 46) || (e == 51) || (e == 56)) ? 4'hF : 4'h0};
      check_val("step", {23'd0, ready, dom_rst, clk_en}, {23'd0, exp_v});
      if (e == 45 || e == 50 || e == 55) step = 1'b1;
      if (e == 47 || e == 52 || e == 57) step = 1'b0;
      if (e == 58) div_ratio[7:0] = 8'd3;
      if (e == 60) step_mode = 1'b0;
    end

    // Leaving step mode restarts every divider with a full period.
    for (int e = 61; e <= 70; e++) begin
      adv();
      exp_v[3] = (e >= 62);
      exp_v[2] = (e >= 62);
      exp_v[1] = (e == 65) || (e == 69);
      exp_v[0] = (e == 64) || (e == 67) || (e == 70);
      exp_v[8:4] = {1'b1, 4'h0};
      check_val("step_exit", {23'd0, ready, dom_rst, clk_en}, {23'd0, exp_v});
      if (e == 70) ext_rstn = 1'b0;
    end

    // Button glitch in RUN: still running for two edges, then full re-sequence.
    for (int e = 71; e <= 72; e++) begin
      adv();
      check_val("glitch_run", {23'd0, ready, dom_rst, clk_en}, {23'd0, 1'b1, 4'h0, 4'hC});
      if (e == 72) ext_rstn = 1'b1;
    end
    for (int e = 73; e <= 110; e++) begin
      adv();
      check_val("rerun", {23'd0, ready, dom_rst, clk_en}, {23'd0, exp_seq(e, 74, 1'b0)});
    end

    // Asynchronous reset between edges takes effect immediately.
    #3;
    rst = 1'b1;
    #1;
    check_val("async_rst", {23'd0, ready, dom_rst, clk_en}, {23'd0, 1'b0, 4'hF, 4'h0});
    for (int e = 0; e < 2; e++) begin
      adv();
      check_val("rst_held", {23'd0, ready, dom_rst, clk_en}, {23'd0, 1'b0, 4'hF, 4'h0});
    end
    rst    = 1'b0;
    edge_n = 0;

    // Button glitch during STRETCH: count restarts once sync_n is high again.
    for (int e = 1; e <= 50; e++) begin
      adv();
      check_val("glitch_stretch", {23'd0, ready, dom_rst, clk_en}, {23'd0, exp_seq(e, 14, 1'b0)});
      if (e == 10) ext_rstn = 1'b0;
      if (e == 12) ext_rstn = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
